// File: rtl/bcd_serial_addsub_ctrl_if.sv
// Request/response bundle for the serial BCD add/subtract sequencer.
// master drives the request side, slave is the sequencer.
interface bcd_serial_addsub_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic                  mode;
    logic                  cin;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result;
    logic                  cout;
    logic                  neg;
    logic                  err;

    modport master (
        output start, mode, cin, a, b,
        input  busy, done, result, cout, neg, err
    );

    modport slave (
        input  start, mode, cin, a, b,
        output busy, done, result, cout, neg, err
    );
endinterface

// File: rtl/bcd_serial_addsub_ctrl.sv
// Multi-digit BCD add/subtract using one shared digit step, LSD first, one digit per clock.
// Define BCD_SIGNMAG_EN to turn negative differences into sign + magnitude via a FIX pass.
module bcd_serial_addsub_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    bcd_serial_addsub_ctrl_if.slave  bus_io
);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    typedef logic [DIGITS-1:0][3:0] bcd_t;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StCalc,
`ifdef BCD_SIGNMAG_EN
        StFix,
`endif
        StDone
    } state_e;

    state_e          state_q, state_d;
    bcd_t            a_q, a_d, b_q, b_d, r_q, r_d;
    logic            mode_q, mode_d;
    logic            carry_q, carry_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            chk_q, chk_d;
    logic            bad_q, bad_d;
    bcd_t            result_q;
    logic            cout_q, neg_q, err_q;

    logic            load_out;
    bcd_t            ld_result;
    logic            ld_cout, ld_neg, ld_err;

    logic            in_fix;
    logic            bad_digit;
    logic            step_sub, step_carry;
    logic [3:0]      step_a, step_b, step_bt, step_digit;
    logic [4:0]      step_sum, step_adj;

`ifdef BCD_SIGNMAG_EN
    assign in_fix = (state_q == StFix);
`else
    assign in_fix = 1'b0;
`endif

    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (a_q[i] > 4'd9 || b_q[i] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Shared digit step: FIX reuses it as 0 - R to recover the magnitude.
    always_comb begin
        step_sub = mode_q | in_fix;
        step_a   = in_fix ? 4'd0 : a_q[idx_q];
        step_b   = in_fix ? r_q[idx_q] : b_q[idx_q];
        step_bt  = step_sub ? (4'd9 - step_b) : step_b;
        step_sum = {1'b0, step_a} + {1'b0, step_bt} + {4'd0, carry_q};
        step_adj = step_sum + 5'd6;
        if (step_sum > 5'd9) begin
            step_digit = step_adj[3:0];
            step_carry = 1'b1;
        end else begin
            step_digit = step_sum[3:0];
            step_carry = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        mode_d    = mode_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        bad_d     = bad_q;
        load_out  = 1'b0;
        ld_result = '0;
        ld_cout   = 1'b0;
        ld_neg    = 1'b0;
        ld_err    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    a_d     = bus_io.a;
                    b_d     = bus_io.b;
                    mode_d  = bus_io.mode;
                    carry_d = bus_io.mode | bus_io.cin;
                    idx_d   = '0;
                    chk_d   = 1'b0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                // Digit-compare verdict is registered before it steers the FSM.
                if (!chk_q) begin
                    bad_d = bad_digit;
                    chk_d = 1'b1;
                end else if (bad_q) begin
                    state_d  = StDone;
                    load_out = 1'b1;
                    ld_err   = 1'b1;
                end else begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                r_d[idx_q] = step_digit;
                carry_d    = step_carry;
                idx_d      = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    idx_d = '0;
`ifdef BCD_SIGNMAG_EN
                    if (mode_q && !step_carry) begin
                        state_d = StFix;
                        carry_d = 1'b1;
                    end else begin
                        state_d   = StDone;
                        load_out  = 1'b1;
                        ld_result = r_d;
                        ld_cout   = step_carry;
                        ld_neg    = 1'b0;
                    end
`else
                    state_d   = StDone;
                    load_out  = 1'b1;
                    ld_result = r_d;
                    ld_cout   = step_carry;
                    ld_neg    = mode_q & ~step_carry;
`endif
                end
            end
`ifdef BCD_SIGNMAG_EN
            StFix: begin
                r_d[idx_q] = step_digit;
                carry_d    = step_carry;
                idx_d      = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    // FIX is only reached on a negative difference: cout=0, neg=1.
                    idx_d     = '0;
                    state_d   = StDone;
                    load_out  = 1'b1;
                    ld_result = r_d;
                    ld_cout   = 1'b0;
                    ld_neg    = 1'b1;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            mode_q   <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            chk_q    <= 1'b0;
            bad_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            bad_q   <= bad_d;
            if (load_out) begin
                result_q <= ld_result;
                cout_q   <= ld_cout;
                neg_q    <= ld_neg;
                err_q    <= ld_err;
            end
        end
    end

    assign bus_io.busy   = (state_q != StIdle) && (state_q != StDone);
    assign bus_io.done   = (state_q == StDone);
    assign bus_io.result = result_q;
    assign bus_io.cout   = cout_q;
    assign bus_io.neg    = neg_q;
    assign bus_io.err    = err_q;
endmodule
